// File: rtl/serv_csr_pkg.sv
// Shared constants for the SERV machine-mode CSR / interrupt unit.
// Bit positions, cause codes, write modes and the writable-interrupt-bit mask.
package serv_csr_pkg;

  typedef enum logic [1:0] {
    CSR_SOURCE_CSR = 2'b00,
    CSR_SOURCE_EXT = 2'b01,
    CSR_SOURCE_SET = 2'b10,
    CSR_SOURCE_CLR = 2'b11
  } csr_source_e;

  localparam logic [4:0] MIE_B  = 5'd3;
  localparam logic [4:0] MPIE_B = 5'd7;
  localparam logic [4:0] MSI_B  = 5'd3;
  localparam logic [4:0] MTI_B  = 5'd7;
  localparam logic [4:0] MEI_B  = 5'd11;
  localparam int         FAST_BASE = 16;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  // Bits of mie/mip that exist for a given number of fast interrupt lines.
  function automatic logic [31:0] irq_mask(input int n);
    logic [31:0] m;
    m = '0;
    m[MSI_B] = 1'b1;
    m[MTI_B] = 1'b1;
    m[MEI_B] = 1'b1;
    for (int k = 0; k < n; k++) m[FAST_BASE+k] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/serv_csr_irq_arb.sv
// Interrupt arbiter: fixed-priority cause selection plus the registered
// pending level and its single-cycle rising-edge pulse.
module serv_irq_arb
  import serv_csr_pkg::*;
#(
  parameter int NUM_FAST_IRQ = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_mip,
  input  logic [31:0] i_mie,
  input  logic        i_global_ie,
  output logic        o_irq_sel,
  output logic [4:0]  o_cause,
  output logic        o_pending,
  output logic        o_new_irq
);

  localparam logic [31:0] IRQ_MASK = irq_mask(NUM_FAST_IRQ);

  logic [31:0] active;
  logic        pend_now;

  assign active    = i_mip & i_mie & IRQ_MASK;
  assign o_irq_sel = |active;
  assign pend_now  = i_global_ie & o_irq_sel;

  // Lowest priority first so higher-priority sources overwrite the choice.
  always_comb begin
    o_cause = '0;
    for (int k = NUM_FAST_IRQ - 1; k >= 0; k--)
      if (active[FAST_BASE+k]) o_cause = 5'(FAST_BASE + k);
    if (active[MTI_B]) o_cause = CAUSE_MTI;
    if (active[MSI_B]) o_cause = CAUSE_MSI;
    if (active[MEI_B]) o_cause = CAUSE_MEI;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pending <= 1'b0;
      o_new_irq <= 1'b0;
    end else begin
      o_pending <= pend_now;
      o_new_irq <= pend_now & ~o_pending;
    end
  end

endmodule

// File: rtl/serv_csr_irq.sv
// Bit-serial machine-mode CSR unit: mstatus (MIE/MPIE), mie, mip, mcause,
// with software/timer/external and NUM_FAST_IRQ platform interrupts.
module serv_csr_irq
  import serv_csr_pkg::*;
#(
  parameter int NUM_FAST_IRQ = 4,
  parameter bit WITH_MPIE    = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic [2:0]            i_cnt,
  input  logic [3:0]            i_cnt_r,
  input  logic                  i_mstatus_en,
  input  logic                  i_mie_en,
  input  logic                  i_mip_en,
  input  logic                  i_mcause_en,
  input  logic [1:0]            i_csr_source,
  input  logic                  i_d,
  output logic                  o_q,
  input  logic                  i_rf_csr_out,
  output logic                  o_csr_in,
  input  logic                  i_trap,
  input  logic                  i_mret,
  input  logic [3:0]            i_mcause,
  input  logic                  i_msip,
  input  logic                  i_mtip,
  input  logic                  i_meip,
  input  logic [((NUM_FAST_IRQ > 0) ? NUM_FAST_IRQ : 1)-1:0] i_fast_irq,
  output logic                  o_irq_pending,
  output logic                  o_new_irq
);

  localparam logic [31:0] IRQ_MASK = irq_mask(NUM_FAST_IRQ);

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_r;
  logic        mcause_int;
  logic [4:0]  mcause_code;

  logic [1:0]  cnt_lsb;
  logic [4:0]  bit_idx;
  logic [31:0] mstatus_w;
  logic [31:0] mip_w;
  logic [31:0] mcause_w;
  logic        sel_bit;
  logic        csr_in;
  logic        irq_sel;
  logic [4:0]  irq_cause;
  logic        unused_fast;

  always_comb begin
    case (i_cnt_r)
      4'b0010: cnt_lsb = 2'd1;
      4'b0100: cnt_lsb = 2'd2;
      4'b1000: cnt_lsb = 2'd3;
      default: cnt_lsb = 2'd0;
    endcase
  end

  assign bit_idx = {i_cnt, cnt_lsb};

  always_comb begin
    mstatus_w         = '0;
    mstatus_w[MIE_B]  = mstatus_mie;
    mstatus_w[MPIE_B] = WITH_MPIE ? mstatus_mpie : 1'b0;
  end

  always_comb begin
    mip_w        = '0;
    mip_w[MSI_B] = i_msip;
    mip_w[MTI_B] = i_mtip;
    mip_w[MEI_B] = i_meip;
    for (int k = 0; k < NUM_FAST_IRQ; k++) mip_w[FAST_BASE+k] = i_fast_irq[k];
  end

  // Keeps the spare one-bit fast line referenced when no fast interrupts exist.
  assign unused_fast = ^i_fast_irq;

  assign mcause_w = {mcause_int, 26'b0, mcause_code};

  assign sel_bit = (i_mstatus_en & mstatus_w[bit_idx]) |
                   (i_mie_en     & mie_r[bit_idx])     |
                   (i_mip_en     & mip_w[bit_idx])     |
                   (i_mcause_en  & mcause_w[bit_idx]);

  assign o_q = i_rf_csr_out | (i_run & sel_bit);

  always_comb begin
    case (csr_source_e'(i_csr_source))
      CSR_SOURCE_EXT: csr_in = i_d;
      CSR_SOURCE_SET: csr_in = o_q | i_d;
      CSR_SOURCE_CLR: csr_in = o_q & ~i_d;
      default:        csr_in = o_q;
    endcase
  end

  assign o_csr_in = csr_in;

  serv_irq_arb #(
    .NUM_FAST_IRQ(NUM_FAST_IRQ)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mip       (mip_w),
    .i_mie       (mie_r),
    .i_global_ie (mstatus_mie),
    .o_irq_sel   (irq_sel),
    .o_cause     (irq_cause),
    .o_pending   (o_irq_pending),
    .o_new_irq   (o_new_irq)
  );

  // Trap and mret are placed after the serial writes so they win any overlap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_r        <= '0;
      mcause_int   <= 1'b0;
      mcause_code  <= '0;
    end else begin
      if (i_run && i_mstatus_en) begin
        if (bit_idx == MIE_B) mstatus_mie <= csr_in;
        if (bit_idx == MPIE_B && WITH_MPIE) mstatus_mpie <= csr_in;
      end
      if (i_run && i_mie_en && IRQ_MASK[bit_idx]) mie_r[bit_idx] <= csr_in;
      if (i_run && i_mcause_en) begin
        if (bit_idx == 5'd31) mcause_int <= csr_in;
        else if (bit_idx < 5'd5) mcause_code[bit_idx[2:0]] <= csr_in;
      end

      if (i_trap) begin
        if (irq_sel && mstatus_mie) begin
          mcause_int  <= 1'b1;
          mcause_code <= irq_cause;
        end else begin
          mcause_int  <= 1'b0;
          mcause_code <= {1'b0, i_mcause};
        end
        mstatus_mpie <= WITH_MPIE ? mstatus_mie : 1'b0;
        mstatus_mie  <= 1'b0;
      end else if (i_mret) begin
        mstatus_mie  <= WITH_MPIE ? mstatus_mpie : 1'b0;
        mstatus_mpie <= WITH_MPIE;
      end
    end
  end

endmodule

// File: tb/tb_serv_csr_irq.sv
// Directed self-checking bench for serv_csr_irq (NUM_FAST_IRQ=4, WITH_MPIE=1).
// Serial CSR accesses are driven one bit per cycle, LSB first.
module tb_serv_csr_irq;

  localparam int SEL_MSTATUS = 0;
  localparam int SEL_MIE     = 1;
  localparam int SEL_MIP     = 2;
  localparam int SEL_MCAUSE  = 3;

  localparam logic [1:0] SRC_CSR = 2'b00;
  localparam logic [1:0] SRC_EXT = 2'b01;
  localparam logic [1:0] SRC_SET = 2'b10;
  localparam logic [1:0] SRC_CLR = 2'b11;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_run = 1'b0;
  logic [2:0] i_cnt = '0;
  logic [3:0] i_cnt_r = 4'b0001;
  logic       i_mstatus_en = 1'b0;
  logic       i_mie_en = 1'b0;
  logic       i_mip_en = 1'b0;
  logic       i_mcause_en = 1'b0;
  logic [1:0] i_csr_source = SRC_CSR;
  logic       i_d = 1'b0;
  logic       o_q;
  logic       i_rf_csr_out = 1'b0;
  logic       o_csr_in;
  logic       i_trap = 1'b0;
  logic       i_mret = 1'b0;
  logic [3:0] i_mcause = '0;
  logic       i_msip = 1'b0;
  logic       i_mtip = 1'b0;
  logic       i_meip = 1'b0;
  logic [3:0] i_fast_irq = '0;
  logic       o_irq_pending;
  logic       o_new_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic [31:0] wb;

  serv_csr_irq #(
    .NUM_FAST_IRQ(4),
    .WITH_MPIE(1'b1)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_run         (i_run),
    .i_cnt         (i_cnt),
    .i_cnt_r       (i_cnt_r),
    .i_mstatus_en  (i_mstatus_en),
    .i_mie_en      (i_mie_en),
    .i_mip_en      (i_mip_en),
    .i_mcause_en   (i_mcause_en),
    .i_csr_source  (i_csr_source),
    .i_d           (i_d),
    .o_q           (o_q),
    .i_rf_csr_out  (i_rf_csr_out),
    .o_csr_in      (o_csr_in),
    .i_trap        (i_trap),
    .i_mret        (i_mret),
    .i_mcause      (i_mcause),
    .i_msip        (i_msip),
    .i_mtip        (i_mtip),
    .i_meip        (i_meip),
    .i_fast_irq    (i_fast_irq),
    .o_irq_pending (o_irq_pending),
    .o_new_irq     (o_new_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full 32-cycle serial access; returns read bits and write-back bits.
  task automatic applyStimulus(input int sel, input logic [1:0] src, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic [31:0] wback);
    rdata = '0;
    wback = '0;
    for (int b = 0; b < 32; b++) begin
      @(posedge i_clk); #1;
      i_run        = 1'b1;
      i_cnt        = 3'(b >> 2);
      i_cnt_r      = 4'b0001 << (b % 4);
      i_mstatus_en = (sel == SEL_MSTATUS);
      i_mie_en     = (sel == SEL_MIE);
      i_mip_en     = (sel == SEL_MIP);
      i_mcause_en  = (sel == SEL_MCAUSE);
      i_csr_source = src;
      i_d          = wdata[b];
      @(negedge i_clk);
      rdata[b] = o_q;
      wback[b] = o_csr_in;
    end
    @(posedge i_clk); #1;
    i_run        = 1'b0;
    i_mstatus_en = 1'b0;
    i_mie_en     = 1'b0;
    i_mip_en     = 1'b0;
    i_mcause_en  = 1'b0;
    i_csr_source = SRC_CSR;
    i_d          = 1'b0;
  endtask

  task automatic readCsr(input int sel, output logic [31:0] rdata);
    logic [31:0] unused_wb;
    applyStimulus(sel, SRC_CSR, 32'h0, rdata, unused_wb);
  endtask

  task automatic pulseStrobe(input logic trap, input logic mret, input logic [3:0] cause);
    @(posedge i_clk); #1;
    i_trap   = trap;
    i_mret   = mret;
    i_mcause = cause;
    @(posedge i_clk); #1;
    i_trap = 1'b0;
    i_mret = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("reset_pending", {31'b0, o_irq_pending}, 32'h0);
    checkOutput("reset_new_irq", {31'b0, o_new_irq}, 32'h0);
    readCsr(SEL_MSTATUS, rd); checkOutput("reset_mstatus", rd, 32'h0);
    readCsr(SEL_MIE, rd);     checkOutput("reset_mie", rd, 32'h0);
    readCsr(SEL_MCAUSE, rd);  checkOutput("reset_mcause", rd, 32'h0);
    readCsr(SEL_MIP, rd);     checkOutput("idle_mip", rd, 32'h0);

    // Reset lands on the same edge as the EXT write of MIE.
    for (int b = 0; b < 4; b++) begin
      @(posedge i_clk); #1;
      i_run = 1'b1; i_mstatus_en = 1'b1; i_csr_source = SRC_EXT;
      i_cnt = 3'd0; i_cnt_r = 4'b0001 << b;
      i_d = (b == 3); i_rst = (b == 3);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_run = 1'b0; i_mstatus_en = 1'b0; i_d = 1'b0; i_csr_source = SRC_CSR;
    readCsr(SEL_MSTATUS, rd); checkOutput("rst_mid_write_mstatus", rd, 32'h0);

    applyStimulus(SEL_MIE, SRC_EXT, 32'hFFFF_FFFF, rd, wb);
    readCsr(SEL_MIE, rd); checkOutput("mie_writable_bits", rd, 32'h000F_0888);
    applyStimulus(SEL_MCAUSE, SRC_EXT, 32'h8000_001F, rd, wb);
    readCsr(SEL_MCAUSE, rd); checkOutput("mcause_ext_write", rd, 32'h8000_001F);

    // Timer interrupt path.
    applyStimulus(SEL_MIE, SRC_EXT, 32'h0000_0080, rd, wb);
    applyStimulus(SEL_MSTATUS, SRC_SET, 32'h0000_0008, rd, wb);
    checkOutput("set_mstatus_csr_in", wb, 32'h0000_0008);
    readCsr(SEL_MSTATUS, rd); checkOutput("mstatus_mie_set", rd, 32'h0000_0008);
    @(posedge i_clk); #1 i_mtip = 1'b1;
    @(negedge i_clk);
    checkOutput("pending_not_yet", {31'b0, o_irq_pending}, 32'h0);
    @(negedge i_clk);
    checkOutput("pending_rise", {31'b0, o_irq_pending}, 32'h1);
    checkOutput("new_irq_pulse", {31'b0, o_new_irq}, 32'h1);
    @(negedge i_clk);
    checkOutput("pending_hold", {31'b0, o_irq_pending}, 32'h1);
    checkOutput("new_irq_single", {31'b0, o_new_irq}, 32'h0);
    pulseStrobe(1'b1, 1'b0, 4'd0);
    readCsr(SEL_MCAUSE, rd);  checkOutput("mcause_mti", rd, 32'h8000_0007);
    readCsr(SEL_MSTATUS, rd); checkOutput("mstatus_after_trap", rd, 32'h0000_0080);
    checkOutput("pending_drop", {31'b0, o_irq_pending}, 32'h0);
    i_mtip = 1'b0;

    // Priority: MEI over MSI over fast 0.
    applyStimulus(SEL_MIE, SRC_EXT, 32'h0001_0888, rd, wb);
    i_meip = 1'b1; i_msip = 1'b1; i_fast_irq = 4'b0001;
    readCsr(SEL_MIP, rd); checkOutput("mip_levels", rd, 32'h0001_0808);
    applyStimulus(SEL_MSTATUS, SRC_SET, 32'h0000_0008, rd, wb);
    pulseStrobe(1'b1, 1'b0, 4'd0);
    readCsr(SEL_MCAUSE, rd); checkOutput("mcause_mei", rd, 32'h8000_000B);
    applyStimulus(SEL_MIE, SRC_CLR, 32'h0000_0800, rd, wb);
    readCsr(SEL_MIE, rd); checkOutput("mie_clr_meie", rd, 32'h0001_0088);
    applyStimulus(SEL_MSTATUS, SRC_SET, 32'h0000_0008, rd, wb);
    pulseStrobe(1'b1, 1'b0, 4'd0);
    readCsr(SEL_MCAUSE, rd); checkOutput("mcause_msi", rd, 32'h8000_0003);
    i_meip = 1'b0; i_msip = 1'b0; i_fast_irq = 4'b0000;

    // Lines dropped before the trap: exception path despite MIE=1.
    applyStimulus(SEL_MSTATUS, SRC_SET, 32'h0000_0008, rd, wb);
    pulseStrobe(1'b1, 1'b0, 4'd2);
    readCsr(SEL_MCAUSE, rd);  checkOutput("mcause_exc_lines_low", rd, 32'h0000_0002);
    readCsr(SEL_MSTATUS, rd); checkOutput("mstatus_exc_mie1", rd, 32'h0000_0080);
    pulseStrobe(1'b1, 1'b0, 4'd5);
    readCsr(SEL_MCAUSE, rd);  checkOutput("mcause_exc_mie0", rd, 32'h0000_0005);
    readCsr(SEL_MSTATUS, rd); checkOutput("mstatus_exc_mie0", rd, 32'h0000_0000);
    pulseStrobe(1'b0, 1'b1, 4'd0);
    readCsr(SEL_MSTATUS, rd); checkOutput("mstatus_mret", rd, 32'h0000_0080);

    // Fast interrupt 2 and read-only mip.
    applyStimulus(SEL_MIE, SRC_EXT, 32'h0004_0000, rd, wb);
    i_fast_irq = 4'b0100;
    readCsr(SEL_MIP, rd); checkOutput("mip_fast2", rd, 32'h0004_0000);
    applyStimulus(SEL_MIP, SRC_EXT, 32'hFFFF_FFFF, rd, wb);
    readCsr(SEL_MIP, rd); checkOutput("mip_read_only", rd, 32'h0004_0000);
    applyStimulus(SEL_MSTATUS, SRC_SET, 32'h0000_0008, rd, wb);
    pulseStrobe(1'b1, 1'b0, 4'd0);
    readCsr(SEL_MCAUSE, rd); checkOutput("mcause_fast2", rd, 32'h8000_0012);
    i_fast_irq = 4'b0000;

    // Simultaneous trap and mret: trap wins.
    applyStimulus(SEL_MSTATUS, SRC_EXT, 32'h0000_0008, rd, wb);
    readCsr(SEL_MSTATUS, rd); checkOutput("mstatus_mie1_mpie0", rd, 32'h0000_0008);
    pulseStrobe(1'b1, 1'b1, 4'd0);
    readCsr(SEL_MSTATUS, rd); checkOutput("trap_beats_mret", rd, 32'h0000_0080);
    readCsr(SEL_MCAUSE, rd);  checkOutput("trap_mret_mcause", rd, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serv_csr_irq.md
Name: serv_csr_irq

Overview:
Bit-serial machine-mode CSR unit for the SERV core. It is the parametrised successor of the single-timer CSR block. It holds mstatus (MIE, MPIE), mie and mcause, and presents a read-only mip. It supports software, timer and external interrupts plus NUM_FAST_IRQ platform ("fast") interrupts at cause 16+k. Sits between the decoder/state machine and the register-file CSR port, one bit per cycle, LSB first.

Parameters:
NUM_FAST_IRQ, 4, number of fast interrupt lines, legal 0..16, mapped to mie/mip/cause bits 16..16+N-1
WITH_MPIE, 1, 1 = implement mstatus.MPIE and mret restore; 0 = MPIE reads 0 and mret sets MIE=0

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous, active-high reset
i_run  in  1  serial CSR access in progress this cycle
i_cnt  in  3  [4:2] nibble counter of the serial bit index
i_cnt_r  in  4  one-hot position within nibble; bit index b = {i_cnt, log2(i_cnt_r)}
i_mstatus_en  in  1  access targets mstatus
i_mie_en  in  1  access targets mie
i_mip_en  in  1  access targets mip (read-only)
i_mcause_en  in  1  access targets mcause
i_csr_source  in  2  write mode: CSR (keep), EXT (write), SET, CLR
i_d  in  1  serial operand bit
o_q  out  1  serial read bit of the selected CSR at index b
i_rf_csr_out  in  1  serial bit from register-file-backed CSRs (mscratch, mtvec, mepc, mtval)
o_csr_in  out  1  serial write-back bit to register file
i_trap  in  1  trap entry strobe (1 cycle)
i_mret  in  1  mret strobe (1 cycle)
i_mcause  in  4  synchronous exception code, used when no interrupt is taken
i_msip  in  1  software interrupt level
i_mtip  in  1  timer interrupt level
i_meip  in  1  external interrupt level
i_fast_irq  in  max(N,1)  fast interrupt levels, synchronous to i_clk
o_irq_pending  out  1  registered: MIE & |(mip & mie)
o_new_irq  out  1  registered 1-cycle pulse on rising edge of o_irq_pending

Behaviour:
- Reset: MIE=0, MPIE=0, mie=0, mcause=0, o_irq_pending=0, o_new_irq=0. Reset has priority over every strobe, including mid-access.
- Bit map: mstatus MIE=b3, MPIE=b7. mie/mip MSI=b3, MTI=b7, MEI=b11, fast k=b(16+k). All other bits read 0 and ignore writes. mcause code in bits [4:0], interrupt flag b31.
- o_q = i_rf_csr_out | (i_run & selected-register bit at b). Each en gates its own register.
- csr_in: EXT -> i_d; SET -> o_q|i_d; CLR -> o_q&~i_d; CSR -> o_q. o_csr_in = csr_in.
- Serial write: a storage bit updates with csr_in in the cycle i_run & its en & index==b. mip writes are discarded.
- Interrupt selection is combinational from mip & mie. Priority: MEI > MSI > MTI > fast 0 > ... > fast N-1.
- i_trap:
  - Irq selected & MIE=1: mcause={1, code 11/3/7/16+k}.
  - Otherwise: mcause={0, 0, i_mcause}.
  - In both cases MPIE<=MIE and MIE<=0.
- i_mret: MIE<=MPIE, MPIE<=1 (WITH_MPIE=1).
- Same cycle trap+mret: trap wins. Same cycle trap + serial write of the same bit: trap wins.
- o_irq_pending updates 1 cycle after its inputs change.
- o_new_irq = pending_now & !pending_prev, exactly one cycle. Re-arms only after o_irq_pending drops.
- Irq line deasserted before the trap: no mcause interrupt recorded. The exception path applies.
- NUM_FAST_IRQ=0: i_fast_irq is ignored, bits 16+ read 0.

Decomposition:
- Package serv_csr_pkg:
  - CSR_SOURCE_CSR=2'b00, EXT=2'b01, SET=2'b10, CLR=2'b11
  - bit positions MIE_B=3, MPIE_B=7, MSI_B=3, MTI_B=7, MEI_B=11, FAST_BASE=16
  - cause codes 3, 7, 11
- Sub-module serv_irq_arb (parameter NUM_FAST_IRQ):
  - inputs: mip, mie, MIE
  - outputs: any-pending, 5-bit cause, registered pending and new-irq pulse

Test Plan:
- Reset mid-write (i_rst during b=3 EXT write of 1 to mstatus) -> MIE=0 and mstatus reads 0x00000000.
- EXT write mie=0x00000080, SET mstatus 0x8, raise i_mtip -> o_irq_pending=1 one cycle later, o_new_irq single-cycle pulse. i_trap -> mcause reads 0x80000007, mstatus reads 0x80.
- i_meip, i_msip, i_fast_irq[0] all high, mie=0x00010888, MIE=1, i_trap -> mcause=0x8000000B. Clear MEIE and repeat -> 0x80000003.
- MIE=0, i_mcause=4'd2, i_trap -> mcause=0x00000002. Then i_mret -> MIE=MPIE=0 then MPIE=1, mstatus reads 0x80.
- N=4, fast irq 2 only, mie bit18 set, trap -> mcause=0x80000012. Read mip while i_fast_irq=4'b0100 -> 0x00040000. EXT write 0xFFFFFFFF to mip -> unchanged.
- Same-cycle i_trap & i_mret with MIE=1, MPIE=0 -> MIE=0, MPIE=1 (trap wins).
